// File: rtl/mem_bus_master.sv
// mem_bus_master: req/ack bus initiator sequencing CPU reads and writes onto
// a shared 8-bit bidirectional data bus serving a 1 KB RAM and an 8 KB ROM.
// Every output is registered. The bus is only driven during RAM writes.
module mem_bus_master #(
    parameter logic [2:0]  RAM_TAG = 3'b110,
    parameter int unsigned RD_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [12:0] cpu_addr,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ack,
    output logic        err,
    output logic        busy,
    output logic [12:0] mem_addr,
    inout  logic [7:0]  data,
    output logic        rd,
    output logic        wr,
    output logic        ram_ena,
    output logic        rom_ena
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACCESS,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD
    } state_t;

    localparam logic [3:0] RD_LAST = 4'(RD_WAIT);

    state_t      state, state_n;
    logic [3:0]  counter, counter_n;
    logic        is_ram, is_ram_n;
    logic [7:0]  wdata_q, wdata_n;
    logic        data_oe, data_oe_n;
    logic [7:0]  rdata_n;
    logic        ack_n, err_n, busy_n;
    logic [12:0] mem_addr_n;
    logic        rd_n, wr_n, ram_ena_n, rom_ena_n;
    logic        hit;

    // Release the bus unless a RAM write is being set up or held.
    assign data = data_oe ? wdata_q : 'z;

    // Region decode of the incoming request address.
    assign hit = (cpu_addr[12:10] == RAM_TAG);

    // Next-state and next-output logic; every register holds by default
    // except the one-cycle pulses ack/err/wr.
    always_comb begin
        state_n    = state;
        counter_n  = counter;
        is_ram_n   = is_ram;
        wdata_n    = wdata_q;
        data_oe_n  = data_oe;
        rdata_n    = rdata;
        ack_n      = 1'b0;
        err_n      = 1'b0;
        mem_addr_n = mem_addr;
        rd_n       = rd;
        wr_n       = 1'b0;
        ram_ena_n  = ram_ena;
        rom_ena_n  = rom_ena;

        case (state)
            IDLE: begin
                // ack is still high in the cycle after completion, which
                // guarantees one idle cycle between transactions.
                if (req && !ack) begin
                    mem_addr_n = cpu_addr;
                    wdata_n    = wdata;
                    is_ram_n   = hit;
                    counter_n  = '0;
                    if (we) begin
                        state_n = WR_SETUP;
                        // ROM writes are rejected: no enable, no bus drive.
                        if (hit) begin
                            ram_ena_n = 1'b1;
                            data_oe_n = 1'b1;
                        end
                    end else begin
                        state_n   = RD_ACCESS;
                        rd_n      = 1'b1;
                        ram_ena_n = hit;
                        rom_ena_n = !hit;
                    end
                end
            end

            RD_ACCESS: begin
                if (counter == RD_LAST) begin
                    rdata_n   = data;
                    ack_n     = 1'b1;
                    rd_n      = 1'b0;
                    ram_ena_n = 1'b0;
                    rom_ena_n = 1'b0;
                    state_n   = IDLE;
                end else begin
                    counter_n = counter + 4'd1;
                end
            end

            WR_SETUP: begin
                if (is_ram) begin
                    wr_n    = 1'b1;
                    state_n = WR_STROBE;
                end else begin
                    ack_n   = 1'b1;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end
            end

            WR_STROBE: begin
                state_n = WR_HOLD;
            end

            WR_HOLD: begin
                data_oe_n = 1'b0;
                ram_ena_n = 1'b0;
                ack_n     = 1'b1;
                state_n   = IDLE;
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n = (state_n != IDLE);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            counter  <= '0;
            is_ram   <= 1'b0;
            wdata_q  <= '0;
            data_oe  <= 1'b0;
            rdata    <= '0;
            ack      <= 1'b0;
            err      <= 1'b0;
            busy     <= 1'b0;
            mem_addr <= '0;
            rd       <= 1'b0;
            wr       <= 1'b0;
            ram_ena  <= 1'b0;
            rom_ena  <= 1'b0;
        end else begin
            state    <= state_n;
            counter  <= counter_n;
            is_ram   <= is_ram_n;
            wdata_q  <= wdata_n;
            data_oe  <= data_oe_n;
            rdata    <= rdata_n;
            ack      <= ack_n;
            err      <= err_n;
            busy     <= busy_n;
            mem_addr <= mem_addr_n;
            rd       <= rd_n;
            wr       <= wr_n;
            ram_ena  <= ram_ena_n;
            rom_ena  <= rom_ena_n;
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb_mem_bus_master: randomized and directed checks of mem_bus_master against
// a transaction-level reference model (latency, strobe counts, memory image).
module tb_mem_bus_master;

    typedef struct packed {
        int   lat;
        logic [7:0] rdat;
        logic er;
        int   n_wr;
        int   n_ram;
        int   n_rom;
        int   n_rd;
        int   n_oe;
        int   n_busy;
        int   first_wr;
        int   n_bad;
        logic to;
    } obs_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        req3 = 1'b0;
    logic        we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  wdata = '0;

    logic [7:0]  rdata, rdata3;
    logic        ack, err, busy, rd, wr, ram_ena, rom_ena;
    logic        ack3, err3, busy3, rd3, wr3, ram_ena3, rom_ena3;
    logic [12:0] mem_addr, mem_addr3;
    wire  [7:0]  data, data3;

    logic [7:0]  ram_env [1024];
    logic [7:0]  ref_ram [1024];
    logic [7:0]  last_rdata [2];
    int unsigned wr_rises;
    int          checks;
    int          errors;

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_init(input int unsigned i);
        return 8'((i * 37 + 11) ^ (i >> 2));
    endfunction

    function automatic logic [7:0] rom_byte(input logic [12:0] a);
        if (a == 13'h0010) return 8'h3C;
        return 8'(a * 5) ^ 8'(a >> 5);
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("lat=%0d rdata=%02h err=%0b wr=%0d ram=%0d rom=%0d rd=%0d oe=%0d busy=%0d wr_at=%0d bad=%0d timeout=%0b",
                         o.lat, o.rdat, o.er, o.n_wr, o.n_ram, o.n_rom, o.n_rd, o.n_oe, o.n_busy, o.first_wr, o.n_bad, o.to);
    endfunction

    mem_bus_master #(.RAM_TAG(3'b110), .RD_WAIT(1)) dut (
        .clk(clk), .rst(rst), .req(req), .we(we), .cpu_addr(cpu_addr), .wdata(wdata),
        .rdata(rdata), .ack(ack), .err(err), .busy(busy), .mem_addr(mem_addr),
        .data(data), .rd(rd), .wr(wr), .ram_ena(ram_ena), .rom_ena(rom_ena)
    );

    mem_bus_master #(.RAM_TAG(3'b110), .RD_WAIT(3)) dut3 (
        .clk(clk), .rst(rst), .req(req3), .we(we), .cpu_addr(cpu_addr), .wdata(wdata),
        .rdata(rdata3), .ack(ack3), .err(err3), .busy(busy3), .mem_addr(mem_addr3),
        .data(data3), .rd(rd3), .wr(wr3), .ram_ena(ram_ena3), .rom_ena(rom_ena3)
    );

    // Combinational memories answer reads whenever rd and an enable are high.
    assign data  = (rd && (ram_ena || rom_ena)) ?
                   (ram_ena ? ram_env[mem_addr[9:0]] : rom_byte(mem_addr)) : 8'hzz;
    assign data3 = (rd3 && (ram_ena3 || rom_ena3)) ?
                   (ram_ena3 ? ram_env[mem_addr3[9:0]] : rom_byte(mem_addr3)) : 8'hzz;

    // RAM latches the bus on the rising edge of wr.
    initial begin
        for (int i = 0; i < 1024; i++) ram_env[i] = ram_init(i);
        wr_rises = 0;
        forever begin
            @(posedge wr);
            wr_rises++;
            if (ram_ena) ram_env[mem_addr[9:0]] = data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: expected transaction outcome from the access rules.
    task automatic model_txn(input int rw, input logic w, input logic [12:0] a,
                             input logic [7:0] d, input int sel, output obs_t e);
        logic in_ram;
        in_ram = (a[12:10] == 3'b110);
        e = '0;
        if (w && in_ram) begin
            ref_ram[a[9:0]] = d;
            e.lat = 4; e.n_wr = 1; e.first_wr = 2; e.n_ram = 3; e.n_oe = 3; e.n_busy = 3;
            e.rdat = last_rdata[sel];
        end else if (w) begin
            e.lat = 2; e.er = 1'b1; e.n_busy = 1;
            e.rdat = last_rdata[sel];
        end else begin
            e.lat = rw + 2; e.n_rd = rw + 1; e.n_busy = rw + 1;
            if (in_ram) e.n_ram = rw + 1; else e.n_rom = rw + 1;
            e.rdat = in_ram ? ref_ram[a[9:0]] : rom_byte(a);
            last_rdata[sel] = e.rdat;
        end
    endtask

    // Drive one request and record what the bus did until ack (bounded).
    task automatic run_txn(input bit use3, input logic w, input logic [12:0] a,
                           input logic [7:0] d, output obs_t o);
        int k;
        bit done;
        logic s_ack, s_err, s_busy, s_rd, s_wr, s_ram, s_rom, s_oe;
        logic [7:0] s_rdata;
        o = '0;
        @(negedge clk);
        we = w; cpu_addr = a; wdata = d;
        if (use3) req3 = 1'b1; else req = 1'b1;
        k = 0; done = 1'b0;
        while (!done && k < 40) begin
            @(posedge clk); #1;
            k++;
            if (use3) begin
                s_ack = ack3; s_err = err3; s_busy = busy3; s_rd = rd3; s_wr = wr3;
                s_ram = ram_ena3; s_rom = rom_ena3; s_oe = dut3.data_oe; s_rdata = rdata3;
            end else begin
                s_ack = ack; s_err = err; s_busy = busy; s_rd = rd; s_wr = wr;
                s_ram = ram_ena; s_rom = rom_ena; s_oe = dut.data_oe; s_rdata = rdata;
            end
            if (s_wr) begin
                o.n_wr = o.n_wr + 1;
                if (o.first_wr == 0) o.first_wr = k;
            end
            if (s_ram)  o.n_ram  = o.n_ram + 1;
            if (s_rom)  o.n_rom  = o.n_rom + 1;
            if (s_rd)   o.n_rd   = o.n_rd + 1;
            if (s_oe)   o.n_oe   = o.n_oe + 1;
            if (s_busy) o.n_busy = o.n_busy + 1;
            if ((s_wr && s_rd) || (s_oe && s_rd)) o.n_bad = o.n_bad + 1;
            if (s_ack) begin
                done = 1'b1;
                o.lat = k; o.rdat = s_rdata; o.er = s_err;
            end
        end
        req = 1'b0; req3 = 1'b0;
        if (!done) o.to = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [28:0] v;
        bit got;
        obs_t e;
        req = 1'b1; we = 1'b0; cpu_addr = 13'h0010;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            v = {rd, wr, ram_ena, rom_ena, ack, err, busy, dut.data_oe, mem_addr, rdata};
            checks++;
            if (v !== '0) begin
                errors++;
                $display("FAIL reset_state: got %h required 0", v);
            end
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({rd, rom_ena, busy} !== 3'b111) begin
            errors++;
            $display("FAIL accept_after_reset: rd/rom_ena/busy=%b required 111", {rd, rom_ena, busy});
        end
        req = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            if (ack) got = 1'b1;
        end
        model_txn(1, 1'b0, 13'h0010, 8'h00, 0, e);
        checks++;
        if (!got || rdata !== e.rdat) begin
            errors++;
            $display("FAIL reset_first_read: ack=%0b rdata=%02h required ack with %02h", got, rdata, e.rdat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_ram_write_read();
        obs_t o, e;
        run_txn(1'b0, 1'b1, 13'h1805, 8'hA5, o);
        model_txn(1, 1'b1, 13'h1805, 8'hA5, 0, e);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL ram_write: got %s required %s", fmt(o), fmt(e));
        end
        run_txn(1'b0, 1'b0, 13'h1805, 8'h00, o);
        model_txn(1, 1'b0, 13'h1805, 8'h00, 0, e);
        checks++;
        if (o !== e || o.rdat !== 8'hA5) begin
            errors++;
            $display("FAIL ram_readback: got %s required %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_rom_read();
        obs_t o, e;
        run_txn(1'b0, 1'b0, 13'h0010, 8'h00, o);
        model_txn(1, 1'b0, 13'h0010, 8'h00, 0, e);
        checks++;
        if (o !== e || o.rdat !== 8'h3C) begin
            errors++;
            $display("FAIL rom_read: got %s required %s", fmt(o), fmt(e));
        end
        run_txn(1'b0, 1'b0, 13'h1FFF, 8'h00, o);
        model_txn(1, 1'b0, 13'h1FFF, 8'h00, 0, e);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL rom_read_top: got %s required %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_rd_wait3();
        obs_t o, e;
        run_txn(1'b1, 1'b0, 13'h0010, 8'h00, o);
        model_txn(3, 1'b0, 13'h0010, 8'h00, 1, e);
        checks++;
        if (o !== e || o.lat !== 5) begin
            errors++;
            $display("FAIL rd_wait3: got %s required %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_rom_write();
        obs_t o, e;
        int unsigned rises;
        rises = wr_rises;
        run_txn(1'b0, 1'b1, 13'h0100, 8'h5A, o);
        model_txn(1, 1'b1, 13'h0100, 8'h5A, 0, e);
        checks++;
        if (o !== e || rises !== wr_rises) begin
            errors++;
            $display("FAIL rom_write: got %s wr_edges=%0d required %s wr_edges=0",
                     fmt(o), wr_rises - rises, fmt(e));
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] r1, r2;
        int j;
        bit got1, got2, got3, idle_ok;
        obs_t e1, e2;
        r1 = '0; r2 = '0;
        @(negedge clk);
        we = 1'b0; cpu_addr = 13'h1800; req = 1'b1;
        got1 = 1'b0;
        for (int k = 0; k < 20 && !got1; k++) begin
            @(posedge clk); #1;
            if (ack) begin got1 = 1'b1; r1 = rdata; end
        end
        cpu_addr = 13'h1801;
        j = 0; got2 = 1'b0; idle_ok = 1'b0;
        while (!got2 && j < 10) begin
            @(posedge clk); #1;
            j++;
            if (j == 1) idle_ok = !ack && !rd && !busy;
            if (rd) got2 = 1'b1;
        end
        checks++;
        if (!got1 || !got2 || j !== 2 || !idle_ok) begin
            errors++;
            $display("FAIL b2b_gap: rd reasserted %0d cycles after ack (idle=%0b) required 2 (idle=1)", j, idle_ok);
        end
        got3 = 1'b0;
        for (int k = 0; k < 20 && !got3; k++) begin
            @(posedge clk); #1;
            if (ack) begin got3 = 1'b1; r2 = rdata; end
        end
        req = 1'b0;
        model_txn(1, 1'b0, 13'h1800, 8'h00, 0, e1);
        model_txn(1, 1'b0, 13'h1801, 8'h00, 0, e2);
        checks++;
        if (r1 !== e1.rdat) begin
            errors++;
            $display("FAIL b2b_first: rdata=%02h required %02h", r1, e1.rdat);
        end
        checks++;
        if (!got3 || r2 !== e2.rdat) begin
            errors++;
            $display("FAIL b2b_second: ack=%0b rdata=%02h required %02h", got3, r2, e2.rdat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int unsigned rises;
        obs_t o, e;
        rises = wr_rises;
        @(negedge clk);
        we = 1'b1; cpu_addr = 13'h1810; wdata = 8'h77; req = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, ram_ena, wr} !== 3'b110) begin
            errors++;
            $display("FAIL wr_setup_entry: busy/ram_ena/wr=%b required 110", {busy, ram_ena, wr});
        end
        @(negedge clk); rst = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        last_rdata[0] = '0; last_rdata[1] = '0;
        checks++;
        if ({wr, ack, busy, ram_ena, dut.data_oe} !== 5'b0 || wr_rises !== rises) begin
            errors++;
            $display("FAIL reset_in_wr_setup: wr/ack/busy/ram_ena/oe=%b wr_edges=%0d required 00000 and 0",
                     {wr, ack, busy, ram_ena, dut.data_oe}, wr_rises - rises);
        end
        @(negedge clk); rst = 1'b0;
        checks++;
        if (ram_env[10'h010] !== ref_ram[10'h010]) begin
            errors++;
            $display("FAIL ram_after_aborted_write: ram[010]=%02h required %02h", ram_env[10'h010], ref_ram[10'h010]);
        end
        run_txn(1'b0, 1'b0, 13'h1810, 8'h00, o);
        model_txn(1, 1'b0, 13'h1810, 8'h00, 0, e);
        checks++;
        if (o !== e) begin
            errors++;
            $display("FAIL read_after_aborted_write: got %s required %s", fmt(o), fmt(e));
        end

        @(negedge clk);
        we = 1'b0; cpu_addr = 13'h0010; req = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({rd, rom_ena} !== 2'b11) begin
            errors++;
            $display("FAIL rd_access_entry: rd/rom_ena=%b required 11", {rd, rom_ena});
        end
        @(negedge clk); rst = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        last_rdata[0] = '0; last_rdata[1] = '0;
        checks++;
        if ({rd, rom_ena, ack, busy, rdata} !== 12'h000) begin
            errors++;
            $display("FAIL reset_in_rd_access: rd/rom_ena/ack/busy=%b rdata=%02h required 0000 and 00",
                     {rd, rom_ena, ack, busy}, rdata);
        end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({ack, busy} !== 2'b00) begin
            errors++;
            $display("FAIL no_ack_after_abort: ack/busy=%b required 00", {ack, busy});
        end
    endtask

    task automatic test_random();
        obs_t o, e;
        logic w;
        logic [12:0] a;
        logic [7:0] d;
        for (int n = 0; n < 40; n++) begin
            w = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       a = {3'b110, 5'b00000, 5'($urandom_range(0, 31))};
                1:       a = 13'($urandom);
                default: a = {3'b110, 10'($urandom)};
            endcase
            d = 8'($urandom);
            run_txn(1'b0, w, a, d, o);
            model_txn(1, w, a, d, 0, e);
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL random[%0d] we=%0b addr=%04h: got %s required %s", n, w, a, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) ref_ram[i] = ram_init(i);
        last_rdata[0] = '0;
        last_rdata[1] = '0;
        test_reset();
        test_ram_write_read();
        test_rom_read();
        test_rd_wait3();
        test_rom_write();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
